// File: rtl/memu_pkg.sv
// Shared definitions for the sync_memu block.
// Holds the parameter defaults, the response code values and the FSM state encoding.
// No logic; imported by every other file of the block.
package memu_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LANE_WIDTH = 4;

  localparam logic [1:0] RC_OK       = 2'b00;
  localparam logic [1:0] RC_CONFLICT = 2'b01;
  localparam logic [1:0] RC_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/sync_memu_if.sv
// Request/response bus of sync_memu plus the clear control and status.
// Ports: request (Req_valid/Req_ready, Read_sig, Write_sig, Address_in, Data_in, Lane_en),
// clear (Clear_start, Busy), response (Resp_valid/Resp_ready, Data_out, Mem_op_success, Resp_code).
interface sync_memu_if
  import memu_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
);
  localparam int LANES = WORD_WIDTH / LANE_WIDTH;

  logic                  Req_valid;
  logic                  Req_ready;
  logic                  Read_sig;
  logic                  Write_sig;
  logic [ADDR_WIDTH-1:0] Address_in;
  logic [WORD_WIDTH-1:0] Data_in;
  logic [LANES-1:0]      Lane_en;
  logic                  Clear_start;
  logic                  Resp_valid;
  logic                  Resp_ready;
  logic [WORD_WIDTH-1:0] Data_out;
  logic                  Mem_op_success;
  logic [1:0]            Resp_code;
  logic                  Busy;

  modport master (
    output Req_valid, Read_sig, Write_sig, Address_in, Data_in, Lane_en, Clear_start, Resp_ready,
    input  Req_ready, Resp_valid, Data_out, Mem_op_success, Resp_code, Busy
  );

  modport slave (
    input  Req_valid, Read_sig, Write_sig, Address_in, Data_in, Lane_en, Clear_start, Resp_ready,
    output Req_ready, Resp_valid, Data_out, Mem_op_success, Resp_code, Busy
  );

endinterface

// File: rtl/memu_lane_ram.sv
// Single-port word array with per-lane write enable and combinational read.
// Write takes effect at the clock edge; read of the addressed word is same-cycle.
// No backpressure; out-of-range addresses read as zero and must never be written.
module memu_lane_ram
  import memu_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [WORD_WIDTH/LANE_WIDTH-1:0]  lane_en,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [WORD_WIDTH-1:0]             wdata,
  output logic [WORD_WIDTH-1:0]             rdata
);
  localparam int LANES = WORD_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // No reset: array contents survive Global_rst by design.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) begin
          mem[addr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  assign rdata = ({1'b0, addr} < DEPTH_W) ? mem[addr] : '0;

endmodule

// File: rtl/sync_memu.sv
// Lane-masked memory unit with valid/ready request and response channels and a zero-fill sweep.
// Latency: response valid one cycle after accept; clear sweep takes DEPTH cycles.
// Backpressure: a stalled response (Resp_ready low) blocks new requests; Req_ready is low during clear.
// Ports: Global_clk, Global_rst (sync, active-high), bus (sync_memu_if slave modport).
module sync_memu
  import memu_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
  input  logic        Global_clk,
  input  logic        Global_rst,
  sync_memu_if.slave  bus
);
  localparam int LANES = WORD_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t state, state_nxt;

  // One bit wider than the address so a full 2**ADDR_WIDTH sweep ends without wrapping.
  logic [ADDR_WIDTH:0] clr_cnt;

  logic                  req_ready;
  logic                  accept;
  logic [1:0]            code_nxt;
  logic                  ram_we;
  logic [LANES-1:0]      ram_lane;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;
  logic [WORD_WIDTH-1:0] ram_rdata;

  logic                  resp_valid;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  op_success;
  logic [1:0]            resp_code;

  // Range outranks conflict: an out-of-range address is reported as RANGE whatever the op bits say.
  always_comb begin
    code_nxt = RC_OK;
    if ({1'b0, bus.Address_in} >= DEPTH_W) begin
      code_nxt = RC_RANGE;
    end else if (bus.Read_sig == bus.Write_sig) begin
      code_nxt = RC_CONFLICT;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !bus.Clear_start;
        if (bus.Clear_start) begin
          state_nxt = ST_CLEAR;
        end else if (bus.Req_valid) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        req_ready = bus.Resp_ready;
        if (bus.Resp_ready) begin
          state_nxt = bus.Req_valid ? ST_RESP : ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == LAST_W) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = bus.Req_valid && req_ready;

  // The RAM port is owned by the sweep in CLEAR and by accepted writes otherwise.
  // Writes are suppressed while reset is high so a reset aborts the sweep cleanly.
  always_comb begin
    ram_we    = 1'b0;
    ram_lane  = bus.Lane_en;
    ram_addr  = bus.Address_in;
    ram_wdata = bus.Data_in;
    if (state == ST_CLEAR) begin
      ram_we    = !Global_rst;
      ram_lane  = '1;
      ram_addr  = clr_cnt[ADDR_WIDTH-1:0];
      ram_wdata = '0;
    end else begin
      ram_we = !Global_rst && accept && (code_nxt == RC_OK) && bus.Write_sig;
    end
  end

  memu_lane_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_ram (
    .clk     (Global_clk),
    .we      (ram_we),
    .lane_en (ram_lane),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge Global_clk) begin
    if (Global_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Global_clk) begin
    if (Global_rst || state != ST_CLEAR) begin
      clr_cnt <= '0;
    end else begin
      clr_cnt <= clr_cnt + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge Global_clk) begin
    if (Global_rst) begin
      resp_valid <= 1'b0;
      data_out   <= '0;
      op_success <= 1'b0;
      resp_code  <= RC_OK;
    end else if (accept) begin
      resp_valid <= 1'b1;
      data_out   <= (code_nxt == RC_OK && bus.Read_sig) ? ram_rdata : '0;
      op_success <= (code_nxt == RC_OK);
      resp_code  <= code_nxt;
    end else if (resp_valid && bus.Resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign bus.Req_ready      = req_ready;
  assign bus.Resp_valid     = resp_valid;
  assign bus.Data_out       = data_out;
  assign bus.Mem_op_success = op_success;
  assign bus.Resp_code      = resp_code;
  assign bus.Busy           = (state == ST_CLEAR);

endmodule

// File: tb/tb_sync_memu.sv
// Self-checking bench for sync_memu (DEPTH=200 so the RANGE path is reachable).
// Table vectors, hand sequences for backpressure, clear and reset, then random traffic vs an array model.
module tb_sync_memu;

  localparam int WW    = 16;
  localparam int AW    = 8;
  localparam int LW    = 4;
  localparam int DEPTH = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_memu_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW)) bus ();

  sync_memu #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LANE_WIDTH(LW)) dut (
    .Global_clk (clk),
    .Global_rst (rst),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ref_mem [DEPTH];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  lane;
    logic [15:0] exp_d;
    logic [1:0]  exp_c;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for Req_ready, take the accept edge, drop valid.
  task automatic do_req(input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [15:0] data, input logic [3:0] lane);
    int n = 0;
    bus.Read_sig   = rd;
    bus.Write_sig  = wr;
    bus.Address_in = addr;
    bus.Data_in    = data;
    bus.Lane_en    = lane;
    bus.Req_valid  = 1'b1;
    #1;
    while (!bus.Req_ready && n < 300) begin
      step();
      n++;
    end
    chk("accept_ready", {31'b0, bus.Req_ready}, 1);
    step();
    bus.Req_valid = 1'b0;
  endtask

  task automatic chk_resp(input string name, input logic [15:0] exp_d, input logic [1:0] exp_c);
    chk({name, "_vld"}, {31'b0, bus.Resp_valid}, 1);
    chk({name, "_dat"}, {16'b0, bus.Data_out}, {16'b0, exp_d});
    chk({name, "_code"}, {30'b0, bus.Resp_code}, {30'b0, exp_c});
    chk({name, "_ok"}, {31'b0, bus.Mem_op_success}, {31'b0, exp_c == 2'b00});
  endtask

  // Behavioural model: classify the op, return the expected response, update the array on a write.
  task automatic model_op(input bit rd, input bit wr, input logic [7:0] addr,
                          input logic [15:0] data, input logic [3:0] lane,
                          output logic [15:0] exp_d, output logic [1:0] exp_c);
    logic [15:0] mask;
    exp_d = 16'h0;
    if (int'(addr) >= DEPTH) begin
      exp_c = 2'b10;
    end else if (rd == wr) begin
      exp_c = 2'b01;
    end else if (rd) begin
      exp_c = 2'b00;
      exp_d = ref_mem[addr];
    end else begin
      exp_c = 2'b00;
      mask  = {{4{lane[3]}}, {4{lane[2]}}, {4{lane[1]}}, {4{lane[0]}}};
      ref_mem[addr] = (ref_mem[addr] & ~mask) | (data & mask);
    end
  endtask

  task automatic model_req(input string name, input bit rd, input bit wr, input logic [7:0] addr,
                           input logic [15:0] data, input logic [3:0] lane);
    logic [15:0] ed;
    logic [1:0]  ec;
    model_op(rd, wr, addr, data, lane, ed, ec);
    do_req(rd, wr, addr, data, lane);
    chk_resp(name, ed, ec);
  endtask

  initial begin
    logic [7:0]  bb_addr [5];
    bit          bb_wr   [5];
    logic [15:0] bb_exp  [5];
    int          n;

    bus.Req_valid   = 1'b0;
    bus.Read_sig    = 1'b0;
    bus.Write_sig   = 1'b0;
    bus.Address_in  = '0;
    bus.Data_in     = '0;
    bus.Lane_en     = '0;
    bus.Clear_start = 1'b0;
    bus.Resp_ready  = 1'b1;

    tv[0]  = '{1'b0, 1'b1, 8'h0F, 16'hF00F, 4'b1111, 16'h0000, 2'b00};
    tv[1]  = '{1'b1, 1'b0, 8'h0F, 16'h0000, 4'b0000, 16'hF00F, 2'b00};
    tv[2]  = '{1'b0, 1'b1, 8'h0F, 16'hABCD, 4'b0010, 16'h0000, 2'b00};
    tv[3]  = '{1'b1, 1'b0, 8'h0F, 16'h0000, 4'b0000, 16'hF0CF, 2'b00};
    tv[4]  = '{1'b1, 1'b1, 8'h0F, 16'h1234, 4'b1111, 16'h0000, 2'b01};
    tv[5]  = '{1'b0, 1'b0, 8'h0F, 16'h5678, 4'b1111, 16'h0000, 2'b01};
    tv[6]  = '{1'b1, 1'b0, 8'h0F, 16'h0000, 4'b0000, 16'hF0CF, 2'b00};
    tv[7]  = '{1'b1, 1'b0, 8'd250, 16'h0000, 4'b0000, 16'h0000, 2'b10};
    tv[8]  = '{1'b0, 1'b1, 8'd250, 16'hFFFF, 4'b1111, 16'h0000, 2'b10};
    tv[9]  = '{1'b1, 1'b1, 8'd200, 16'hFFFF, 4'b1111, 16'h0000, 2'b10};
    tv[10] = '{1'b0, 1'b1, 8'd199, 16'h1234, 4'b1111, 16'h0000, 2'b00};
    tv[11] = '{1'b1, 1'b0, 8'd199, 16'h0000, 4'b0000, 16'h1234, 2'b00};

    // Reset state
    repeat (3) step();
    chk("rst_resp_valid", {31'b0, bus.Resp_valid}, 0);
    chk("rst_data_out", {16'b0, bus.Data_out}, 0);
    chk("rst_code", {30'b0, bus.Resp_code}, 0);
    chk("rst_success", {31'b0, bus.Mem_op_success}, 0);
    chk("rst_busy", {31'b0, bus.Busy}, 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", {31'b0, bus.Req_ready}, 1);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      do_req(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].data, tv[i].lane);
      chk_resp($sformatf("tv%0d", i), tv[i].exp_d, tv[i].exp_c);
    end
    step();
    chk("tv_drain", {31'b0, bus.Resp_valid}, 0);

    // Backpressure: response held 3 cycles, second request waits then goes through
    bus.Resp_ready = 1'b0;
    bus.Read_sig = 1'b1; bus.Write_sig = 1'b0; bus.Address_in = 8'h0F; bus.Req_valid = 1'b1;
    #1;
    chk("bp_first_ready", {31'b0, bus.Req_ready}, 1);
    step();
    bus.Address_in = 8'd199;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", {31'b0, bus.Req_ready}, 0);
      chk("bp_resp_valid", {31'b0, bus.Resp_valid}, 1);
      chk("bp_data", {16'b0, bus.Data_out}, 32'hF0CF);
      chk("bp_code", {30'b0, bus.Resp_code}, 0);
      step();
    end
    bus.Resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, bus.Req_ready}, 1);
    step();
    bus.Req_valid = 1'b0;
    chk_resp("bp_second", 16'h1234, 2'b00);
    step();
    chk("bp_drain", {31'b0, bus.Resp_valid}, 0);

    // Back-to-back, including read-after-write to the same word on the next cycle
    bb_addr = '{8'h30, 8'h30, 8'h0F, 8'd199, 8'h30};
    bb_wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bb_exp  = '{16'h0000, 16'h5A5A, 16'hF0CF, 16'h1234, 16'h5A5A};
    bus.Data_in = 16'h5A5A; bus.Lane_en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      bus.Read_sig = !bb_wr[i]; bus.Write_sig = bb_wr[i]; bus.Address_in = bb_addr[i];
      bus.Req_valid = 1'b1;
      #1;
      chk("b2b_ready", {31'b0, bus.Req_ready}, 1);
      step();
      chk("b2b_valid", {31'b0, bus.Resp_valid}, 1);
      chk("b2b_data", {16'b0, bus.Data_out}, {16'b0, bb_exp[i]});
    end
    bus.Req_valid = 1'b0;
    step();
    chk("b2b_drain", {31'b0, bus.Resp_valid}, 0);

    // Clear beats a simultaneous request
    bus.Clear_start = 1'b1;
    bus.Req_valid = 1'b1; bus.Read_sig = 1'b0; bus.Write_sig = 1'b1;
    bus.Address_in = 8'h0F; bus.Data_in = 16'hFFFF; bus.Lane_en = 4'hF;
    #1;
    chk("clr_req_blocked", {31'b0, bus.Req_ready}, 0);
    step();
    bus.Clear_start = 1'b0;
    bus.Req_valid = 1'b0;
    chk("clr_no_resp", {31'b0, bus.Resp_valid}, 0);
    chk("clr_ready_low", {31'b0, bus.Req_ready}, 0);
    n = 0;
    while (bus.Busy && n < 1000) begin
      n++;
      step();
    end
    chk("clr_busy_cycles", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 16'h0;
    model_req("clr_rd_0f", 1'b1, 1'b0, 8'h0F, 16'h0, 4'h0);
    model_req("clr_rd_199", 1'b1, 1'b0, 8'd199, 16'h0, 4'h0);
    model_req("clr_rd_0", 1'b1, 1'b0, 8'h00, 16'h0, 4'h0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      int op;
      bit rd, wr;
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 2 && op <= 5);
      wr = (op == 0) || (op >= 6);
      model_req("rand", rd, wr, 8'($urandom_range(0, 215)), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    step();

    // Reset during a pending response: response dropped, write kept
    bus.Resp_ready = 1'b0;
    model_req("rresp_wr", 1'b0, 1'b1, 8'h40, 16'h7777, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rresp_dropped", {31'b0, bus.Resp_valid}, 0);
    bus.Resp_ready = 1'b1;
    model_req("rresp_rd", 1'b1, 1'b0, 8'h40, 16'h0, 4'h0);
    step();

    // Reset at clear address 10 aborts the sweep
    model_req("rclr_w5", 1'b0, 1'b1, 8'd5, 16'h1111, 4'hF);
    model_req("rclr_w12", 1'b0, 1'b1, 8'd12, 16'h2222, 4'hF);
    model_req("rclr_w20", 1'b0, 1'b1, 8'd20, 16'hBEEF, 4'hF);
    step();
    bus.Clear_start = 1'b1;
    step();
    bus.Clear_start = 1'b0;
    repeat (10) step();
    chk("rclr_busy_before", {31'b0, bus.Busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rclr_busy_after", {31'b0, bus.Busy}, 0);
    chk("rclr_ready", {31'b0, bus.Req_ready}, 1);
    chk("rclr_code", {30'b0, bus.Resp_code}, 0);
    for (int a = 0; a < 10; a++) ref_mem[a] = 16'h0;
    for (int a = 0; a <= 20; a++) begin
      model_req($sformatf("rclr_rd%0d", a), 1'b1, 1'b0, 8'(a), 16'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_memu.md
SYNC_MEMU -- requirements
Module: sync_memu

Interface
REQ-001 Parameter: WORD_WIDTH, 16, data word width in bits; SHALL be a multiple of LANE_WIDTH.
REQ-002 Parameter: ADDR_WIDTH, 8, address width in bits.
REQ-003 Parameter: DEPTH, 2**ADDR_WIDTH, number of words; SHALL be at most 2**ADDR_WIDTH.
REQ-004 Parameter: LANE_WIDTH, 4, write-enable granularity in bits (one nibble).
REQ-005 Port: Global_clk  in  1  single clock; all logic on rising edge.
REQ-006 Port: Global_rst  in  1  reset, synchronous, active-high.
REQ-007 Port: Req_valid  in  1  request present.
REQ-008 Port: Req_ready  out  1  request can be accepted this cycle.
REQ-009 Port: Read_sig / Write_sig  in  1 each  operation select.
REQ-010 Port: Address_in  in  ADDR_WIDTH  word address.
REQ-011 Port: Data_in  in  WORD_WIDTH  write data.
REQ-012 Port: Lane_en  in  WORD_WIDTH/LANE_WIDTH  per-lane write enable.
REQ-013 Port: Clear_start  in  1  start whole-array zero fill.
REQ-014 Port: Resp_valid  out  1  response present; Resp_ready  in  1  response consumed.
REQ-015 Port: Data_out  out  WORD_WIDTH  read data.
REQ-016 Port: Mem_op_success  out  1  high when Resp_code is OK.
REQ-017 Port: Resp_code  out  2  00 OK, 01 CONFLICT, 10 RANGE.
REQ-018 Port: Busy  out  1  clear sweep in progress.

Function
REQ-019 FSM states: IDLE, RESP, CLEAR.
REQ-020 A request SHALL be accepted when Req_valid and Req_ready are both high.
REQ-021 Req_ready = (IDLE and not Clear_start) or (RESP and Resp_ready).
REQ-022 Accept SHALL cause Resp_valid high on the next cycle (latency 1); the FSM enters or stays in RESP.
REQ-023 Response SHALL hold stable until Resp_valid and Resp_ready are both high; without a new accept, FSM returns to IDLE.
REQ-024 Back-to-back accepts SHALL sustain one request per cycle while Resp_ready is held high.
REQ-025 Read (Read_sig=1, Write_sig=0): Data_out = mem[Address_in] as of the accept cycle; code OK.
REQ-026 Write (Write_sig=1, Read_sig=0): lanes with Lane_en=1 SHALL be updated in the accept cycle; other lanes are unchanged; Data_out = 0; code OK.
REQ-027 Both or neither of Read_sig/Write_sig: no memory change; Data_out = 0; code CONFLICT.
REQ-028 Address_in >= DEPTH: no memory change; Data_out = 0; code RANGE; RANGE SHALL take precedence over CONFLICT.
REQ-029 A read accepted on the cycle after a write to the same address SHALL return the written data.
REQ-030 Clear_start in IDLE SHALL enter CLEAR the next cycle and take priority over a simultaneous Req_valid; Clear_start in RESP or CLEAR SHALL be ignored.
REQ-031 CLEAR SHALL write zero to one word per cycle, address 0 to DEPTH-1 (DEPTH cycles), then return to IDLE; Busy = 1 exactly in CLEAR; Req_ready = 0 in CLEAR.
REQ-032 The clear address counter SHALL be ADDR_WIDTH+1 bits wide so that DEPTH = 2**ADDR_WIDTH terminates without wrap.

Reset
REQ-033 Global_rst SHALL force IDLE, Resp_valid=0, Data_out=0, Mem_op_success=0, Resp_code=00, Busy=0, and clear counter=0.
REQ-034 Reset SHALL NOT initialise the memory array; reset mid-CLEAR leaves a partially cleared array and aborts the sweep.
REQ-035 Reset while RESP SHALL drop the pending response; no write is undone.

Structure
REQ-036 Package memu_pkg SHALL hold the Resp_code constants, the FSM state encoding, and the parameter defaults.
REQ-037 Sub-module memu_lane_ram: single-port array with per-lane write enable and combinational read; sync_memu holds the FSM, the handshake, and the response registers.

Verification
REQ-038 Write 0xF00F to address 0x0F with Lane_en=1111, then read 0x0F -> Resp_valid one cycle after each accept; read Data_out=0xF00F, code 00.
REQ-039 Write 0xABCD with Lane_en=0010 over 0xF00F, then read -> 0xF0CF.
REQ-040 Read_sig=Write_sig=1 -> code 01, Mem_op_success=0, memory unchanged; DEPTH=200, address 250 -> code 10.
REQ-041 Hold Resp_ready=0 for 3 cycles after accept -> Req_ready=0 and response stable; 4 back-to-back reads with Resp_ready=1 -> 4 responses on consecutive cycles.
REQ-042 Clear_start and Req_valid high together in IDLE -> request not accepted, Busy high for exactly DEPTH cycles, all reads then return 0.
REQ-043 Global_rst asserted at clear address 10 -> IDLE next cycle; words 0-9 read 0; prior data at word 20 intact.
